mips32_prog_loader: RTL and testbench
=====================================

Name: mips32_prog_loader

Overview:
- Byte-stream program/data loader that writes 32-bit words into the pipelined MIPS32 memory through a word write port.
- Holds the core stalled until a complete, checksum-verified image has been written, then releases it with a single start pulse.
- Replaces testbench-side hierarchical pokes of Mem[] with a real hardware path, e.g. fed by a UART/debug byte receiver.

Parameters:
- ADDR_W, 10, memory word-address width.
- DEPTH, 1024, number of addressable words; must be <= 2^ADDR_W.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  in_byte is valid this cycle.
- in_ready  out  1  loader accepts in_byte this cycle; a byte transfers when in_valid && in_ready.
- in_byte  in  8  stream byte.
- mem_we  out  1  one-cycle word write strobe.
- mem_addr  out  ADDR_W  word address for mem_we.
- mem_wdata  out  32  word data for mem_we.
- cpu_hold  out  1  1 = core must not fetch (drives HALTED/stall).
- cpu_start  out  1  one-cycle pulse; the core sets PC=0 and clears HALTED.
- done  out  1  last frame loaded and verified.
- err  out  1  last frame failed (range or checksum).

Behaviour:
- Reset (rst_n=0 at a clock edge), taking priority over everything including mid-frame: state=IDLE, cpu_hold=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_start=0, done=0, err=0; checksum, count and byte index cleared. in_ready rises the cycle after reset releases.
- Frame format, all fields big-endian: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words of 4 bytes each (MSB first), then CSUM.
- CSUM = XOR of every byte from ADDR_H through the last data byte. SYNC is excluded.
- States: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR: accept bytes. Non-SYNC bytes are discarded. A SYNC byte goes to ADDR_H, sets cpu_hold=1, and clears done, err and the checksum.
- ADDR_H → ADDR_L → CNT_H → CNT_L: each field advances on one accepted byte.
  - At CNT_L, if start address + CNT > DEPTH: go to ERR and set err=1. Nothing is written.
  - At CNT_L, if CNT=0: go to CSUM.
  - Otherwise go to DATA.
- DATA: shift each byte into a 32-bit assembler. After the 4th byte, go to WRITE.
- WRITE: lasts exactly 1 cycle.
  - in_ready=0; mem_we=1, mem_addr=current address, mem_wdata=assembled word.
  - Address increments and the remaining count decrements.
  - Next state is CSUM if the count reaches 0, else DATA.
  - Write latency is 1 cycle after the 4th data byte is accepted.
- CSUM: on the accepted byte:
  - Match: cpu_start=1 for one cycle, cpu_hold=0 in that same cycle and after, done=1, go to DONE.
  - Mismatch: err=1, cpu_hold stays 1, go to ERR. Words already written stay in memory; the core is never released.
- in_ready=1 in every state except WRITE.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Address width: the range check is done in ADDR_W+17 bits so the sum cannot wrap. A 16-bit address or count that exceeds DEPTH is an error, not a wrap.
- A new SYNC received after DONE restarts loading and re-asserts cpu_hold immediately. A SYNC byte in the middle of a frame is treated as data.
- cpu_start and mem_we are never both high in the same cycle.

Test Plan:
- Reset → in_ready=0 during reset, cpu_hold=1, done=err=0; in_ready=1 the cycle after rst_n rises.
- Stream A5 00 00 00 02 28 01 00 78 FC 00 00 00 AF → two writes: (0, 32'h28010078) then (1, 32'hFC000000), each 1 cycle after its 4th byte. Then cpu_start pulses once, cpu_hold=0, done=1.
- Same frame with CSUM=0x00 → both words written, err=1, cpu_hold=1, no cpu_start pulse.
- Stream A5 03 FF 00 02 (address 1023, count 2, DEPTH 1024) → err=1 immediately after CNT_L, no mem_we, remaining bytes discarded.
- Stream A5 00 78 00 00 78 (CNT=0; CSUM = 00^78^00^00 = 0x78) → no writes, cpu_start pulse, done=1.
- Assert rst_n=0 after 2 data bytes, then resend the full 2-word frame → clean load with the same two writes; the partial word is never written.
- in_valid held high throughout → in_ready drops exactly on WRITE cycles and no byte is lost or duplicated.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader
// Byte-stream image loader for the pipelined MIPS32 core. It parses framed
// byte streams, writes the payload words into core memory through a single
// word write port, verifies an XOR checksum and only then releases the core
// with a one-cycle start pulse.
//
// Frame (big-endian): SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x 4 data bytes,
// CSUM. CSUM is the XOR of every byte from ADDR_H through the last data byte.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_byte valid this cycle
//   in_ready   loader accepts a byte this cycle (low only in WRITE)
//   in_byte    stream byte
//   mem_we     one-cycle word write strobe
//   mem_addr   word address for mem_we (holds when mem_we=0)
//   mem_wdata  word data for mem_we (holds when mem_we=0)
//   cpu_hold   1 = core must not fetch
//   cpu_start  one-cycle pulse releasing the core from PC=0
//   done       last frame loaded and verified
//   err        last frame failed range or checksum check
module mips32_prog_loader #(
    parameter int          ADDR_W = 10,
    parameter int          DEPTH  = 1024,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              done,
    output logic              err
);

    // Wide enough that a 16-bit address plus a 16-bit count can never wrap.
    localparam int RANGE_W = ADDR_W + 17;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_CNT_H,
        ST_CNT_L,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t               state, state_nxt;
    logic                 ready_en;
    logic                 accept;
    logic [15:0]          addr_q;
    logic [15:0]          cnt_q;
    logic [15:0]          cnt_full;
    logic [7:0]           csum_q;
    logic [23:0]          word_q;
    logic [1:0]           bidx_q;
    logic [RANGE_W-1:0]   range_end;
    logic                 range_bad;

    assign accept    = in_valid && in_ready;
    // Count as it will be once the CNT_L byte is taken.
    assign cnt_full  = {cnt_q[15:8], in_byte};
    assign range_end = RANGE_W'(addr_q) + RANGE_W'(cnt_full);
    assign range_bad = (range_end > RANGE_W'(DEPTH));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and combinational outputs
    always_comb begin
        state_nxt = state;
        // ready_en keeps in_ready low for the first cycle after reset release.
        in_ready  = ready_en && (state != ST_WRITE);
        mem_we    = (state == ST_WRITE);
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (accept && (in_byte == SYNC)) state_nxt = ST_ADDR_H;
            end
            ST_ADDR_H: if (accept) state_nxt = ST_ADDR_L;
            ST_ADDR_L: if (accept) state_nxt = ST_CNT_H;
            ST_CNT_H:  if (accept) state_nxt = ST_CNT_L;
            ST_CNT_L: begin
                if (accept) begin
                    if (range_bad)             state_nxt = ST_ERR;
                    else if (cnt_full == 16'd0) state_nxt = ST_CSUM;
                    else                       state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept && (bidx_q == 2'd3)) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                state_nxt = (cnt_q == 16'd1) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (accept) state_nxt = (in_byte == csum_q) ? ST_DONE : ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame fields, word assembly, write port and core control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            word_q    <= '0;
            bidx_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            cpu_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            cpu_start <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (accept && (in_byte == SYNC)) begin
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        csum_q   <= '0;
                    end
                end
                ST_ADDR_H: begin
                    if (accept) begin
                        addr_q[15:8] <= in_byte;
                        csum_q       <= csum_q ^ in_byte;
                    end
                end
                ST_ADDR_L: begin
                    if (accept) begin
                        addr_q[7:0] <= in_byte;
                        csum_q      <= csum_q ^ in_byte;
                    end
                end
                ST_CNT_H: begin
                    if (accept) begin
                        cnt_q[15:8] <= in_byte;
                        csum_q      <= csum_q ^ in_byte;
                    end
                end
                ST_CNT_L: begin
                    if (accept) begin
                        cnt_q[7:0] <= in_byte;
                        csum_q     <= csum_q ^ in_byte;
                        bidx_q     <= '0;
                        if (range_bad) err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        word_q <= {word_q[15:0], in_byte};
                        csum_q <= csum_q ^ in_byte;
                        bidx_q <= bidx_q + 2'd1;
                        // Latch the write port on the 4th byte so it holds
                        // steady after the strobe while addr_q moves on.
                        if (bidx_q == 2'd3) begin
                            mem_addr  <= ADDR_W'(addr_q);
                            mem_wdata <= {word_q, in_byte};
                        end
                    end
                end
                ST_WRITE: begin
                    addr_q <= addr_q + 16'd1;
                    cnt_q  <= cnt_q - 16'd1;
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (in_byte == csum_q) begin
                            cpu_start <= 1'b1;
                            cpu_hold  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader
// Self-checking bench for mips32_prog_loader. Frames are driven byte by byte;
// every expected memory write (address, data, cycle) is pushed to a queue as
// the 4th byte of its word is accepted, and a monitor pops and compares each
// mem_we strobe. Scenario tasks check control outputs inline.
module tb_mips32_prog_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_byte = 8'h00;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              done;
    logic              err;

    mips32_prog_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SYNC   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .cpu_start (cpu_start),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          starts = 0;
    int          start_cyc = -1;
    bit          chk_rdy = 1'b0;
    logic [31:0] wbuf [0:7];
    int          last_acc_cyc = 0;
    int          csum_cyc = 0;
    logic        hold_after_sync = 1'b0;

    // Monitor: sampled just after the falling edge so the drivers (which act
    // on the falling edge) have already queued their expectations.
    always @(negedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data || cyc != mon_e.cyc) begin
                    miscompares++;
                    $display("FAIL write got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                             mem_addr, mem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
        if (cpu_start === 1'b1) begin
            starts++;
            start_cyc = cyc;
            vectors++;
            if (mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL start_vs_we got mem_we=%b with cpu_start=1, expected 0", mem_we);
            end
        end
        if (chk_rdy) begin
            vectors++;
            if (in_ready !== ~mem_we) begin
                miscompares++;
                $display("FAIL ready_vs_write got in_ready=%b mem_we=%b, expected in_ready=~mem_we", in_ready, mem_we);
            end
        end
    end

    // Offers one byte starting at a falling edge; returns at the falling edge
    // after the rising edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int g = 0; g < 20 && !acc; g++) begin
            acc = (in_ready === 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        last_acc_cyc = cyc;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout byte=%h got in_ready=%b, expected 1", b, in_ready);
        end
    endtask

    // Sends a complete frame holding in_valid high; data words come from wbuf.
    task automatic send_frame(input logic [15:0] a, input logic [15:0] n,
                              input bit ovr, input logic [7:0] ovr_val);
        logic [7:0] x;
        x = a[15:8] ^ a[7:0] ^ n[15:8] ^ n[7:0];
        send_byte(8'hA5);
        hold_after_sync = cpu_hold;
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(wbuf[i][8*k +: 8]);
                x = x ^ wbuf[i][8*k +: 8];
            end
            exp_q.push_back('{addr: ADDR_W'(a + 16'(i)), data: wbuf[i], cyc: last_acc_cyc});
        end
        send_byte(ovr ? ovr_val : x);
        csum_cyc = last_acc_cyc;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
        vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_hold got %b expected 1", cpu_hold); end
        vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_done_err got %b%b expected 00", done, err); end
        vectors++; if (mem_we !== 1'b0 || cpu_start !== 1'b0) begin miscompares++; $display("FAIL reset_strobes got we=%b start=%b expected 0 0", mem_we, cpu_start); end
        vectors++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_port got addr=%0d data=%h expected 0 0", mem_addr, mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset got %b expected 1", in_ready); end
        chk_rdy = 1'b1;
    endtask

    task automatic test_load();
        int s0;
        s0 = starts;
        wbuf[0] = 32'h28010078;
        wbuf[1] = 32'hFC000000;
        send_frame(16'h0000, 16'd2, 1'b1, 8'hAF);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL load_writes got %0d pending expected 0", exp_q.size()); end
        vectors++; if (starts - s0 != 1) begin miscompares++; $display("FAIL load_start_count got %0d expected 1", starts - s0); end
        vectors++; if (start_cyc != csum_cyc) begin miscompares++; $display("FAIL load_start_cycle got %0d expected %0d", start_cyc, csum_cyc); end
        vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL load_done_err got %b%b expected 10", done, err); end
        vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL load_cpu_hold got %b expected 0", cpu_hold); end
    endtask

    task automatic test_bad_csum();
        int s0;
        s0 = starts;
        send_frame(16'h0000, 16'd2, 1'b1, 8'h00);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (hold_after_sync !== 1'b1) begin miscompares++; $display("FAIL resync_hold got %b expected 1", hold_after_sync); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL bad_writes got %0d pending expected 0", exp_q.size()); end
        vectors++; if (starts != s0) begin miscompares++; $display("FAIL bad_start_count got %0d expected 0", starts - s0); end
        vectors++; if (err !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL bad_err_done got %b%b expected 10", err, done); end
        vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL bad_cpu_hold got %b expected 1", cpu_hold); end
    endtask

    task automatic test_range();
        send_byte(8'hA5);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL range_sync_clears_err got %b expected 0", err); end
        send_byte(8'h03);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h02);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL range_err_now got %b expected 1", err); end
        for (int i = 1; i <= 10; i++) send_byte(8'(i * 17));
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL range_after got err=%b hold=%b done=%b expected 1 1 0", err, cpu_hold, done); end
        send_byte(8'hA5);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wide_sync_clears_err got %b expected 0", err); end
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h01);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL wide_addr_err got %b expected 1", err); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_cnt();
        int s0;
        s0 = starts;
        send_frame(16'h0078, 16'd0, 1'b1, 8'h78);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (starts - s0 != 1) begin miscompares++; $display("FAIL zero_start_count got %0d expected 1", starts - s0); end
        vectors++; if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin miscompares++; $display("FAIL zero_status got done=%b err=%b hold=%b expected 1 0 0", done, err, cpu_hold); end
    endtask

    task automatic test_reset_midframe();
        int s0;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h28); send_byte(8'h01);
        chk_rdy  = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL mid_reset got rdy=%b hold=%b done=%b err=%b expected 0 1 0 0", in_ready, cpu_hold, done, err); end
        vectors++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin miscompares++; $display("FAIL mid_reset_port got addr=%0d data=%h expected 0 0", mem_addr, mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready_after got %b expected 1", in_ready); end
        chk_rdy = 1'b1;
        s0 = starts;
        wbuf[0] = 32'h28010078;
        wbuf[1] = 32'hFC000000;
        send_frame(16'h0000, 16'd2, 1'b0, 8'h00);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (exp_q.size() != 0 || starts - s0 != 1 || done !== 1'b1) begin miscompares++; $display("FAIL mid_reload got pending=%0d starts=%0d done=%b expected 0 1 1", exp_q.size(), starts - s0, done); end
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = starts;
        wbuf[0] = 32'hDEADBEEF;
        wbuf[1] = 32'h01234567;
        send_frame(16'd1022, 16'd2, 1'b0, 8'h00);
        wbuf[0] = 32'hA5A5A5A5;
        wbuf[1] = 32'h00FF00FF;
        wbuf[2] = 32'h13579BDF;
        send_frame(16'd5, 16'd3, 1'b0, 8'h00);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_writes got %0d pending expected 0", exp_q.size()); end
        vectors++; if (starts - s0 != 2) begin miscompares++; $display("FAIL b2b_start_count got %0d expected 2", starts - s0); end
        vectors++; if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin miscompares++; $display("FAIL b2b_status got done=%b err=%b hold=%b expected 1 0 0", done, err, cpu_hold); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load();
        test_bad_csum();
        test_range();
        test_zero_cnt();
        test_reset_midframe();
        test_back_to_back();
        chk_rdy = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
